// File: rtl/pc_fetch_unit.sv
// Instruction fetch: steps the PC, requests words from instruction memory and applies branch/jump redirects.
// Latency: a word is delivered one cycle after its ack; stall holds the delivered word and pauses fetching.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    input  logic [31:0] branch_offset,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic        addr_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, SQUASH} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        redir;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;

    assign redir   = jump_en | branch_taken;
    assign tgt_raw = jump_en ? jump_target : (branch_pc + 32'd4 + branch_offset);
    assign tgt     = {tgt_raw[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= 32'd0;
            pc_out     <= 32'd0;
            addr_err   <= 1'b0;
        end else begin
            addr_err <= redir & (|tgt_raw[1:0]);
            case (state)
                FETCH: begin
                    if (redir) begin
                        // Unacked request must stay on the bus; SQUASH drains it.
                        inst_valid <= 1'b0;
                        pc         <= tgt;
                        if (imem_ack) begin
                            imem_addr <= tgt;
                            state     <= FETCH;
                        end else begin
                            state     <= SQUASH;
                        end
                    end else if (imem_ack) begin
                        inst       <= imem_rdata;
                        pc_out     <= pc;
                        pc         <= pc + 32'd4;
                        imem_addr  <= pc + 32'd4;
                        inst_valid <= 1'b1;
                        if (stall) begin
                            imem_req <= 1'b0;
                            state    <= HOLD;
                        end
                    end else begin
                        inst_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redir) begin
                        pc         <= tgt;
                        imem_addr  <= tgt;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                    end else if (!stall) begin
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                        state      <= FETCH;
                    end
                end
                SQUASH: begin
                    inst_valid <= 1'b0;
                    if (redir)
                        pc <= tgt;
                    if (imem_ack) begin
                        imem_addr <= redir ? tgt : pc;
                        state     <= FETCH;
                    end
                end
                default: begin
                    inst_valid <= 1'b0;
                    imem_req   <= 1'b1;
                    state      <= FETCH;
                    if (redir) begin
                        pc        <= tgt;
                        imem_addr <= tgt;
                    end else begin
                        imem_addr <= pc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_pc = 32'd0;
    logic [31:0] branch_offset = 32'd0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        addr_err;

    int checks = 0;
    int failures = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_offset(branch_offset),
        .jump_en(jump_en), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .pc_out(pc_out), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req},   32'd0);
        check({tag, "_addr"},  imem_addr,           32'd0);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_inst"},  inst,                32'd0);
        check({tag, "_pcout"}, pc_out,              32'd0);
        check({tag, "_aerr"},  {31'd0, addr_err},   32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;
        step();
        check("idle_to_fetch_req", {31'd0, imem_req}, 32'd1);
        check("idle_to_fetch_addr", imem_addr, 32'h0);

        // Back-to-back fetch with ack every cycle
        imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
        step();
        check("seq0_valid", {31'd0, inst_valid}, 32'd1);
        check("seq0_pcout", pc_out, 32'h0);
        check("seq0_inst", inst, 32'h1111_0000);
        check("seq0_addr", imem_addr, 32'h4);
        imem_rdata = 32'h1111_0004;
        step();
        check("seq1_pcout", pc_out, 32'h4);
        check("seq1_addr", imem_addr, 32'h8);
        imem_rdata = 32'h1111_0008;
        step();
        check("seq2_pcout", pc_out, 32'h8);
        check("seq2_inst", inst, 32'h1111_0008);
        check("seq2_addr", imem_addr, 32'hC);
        imem_ack = 1'b0;
        step();
        check("seq_pulse_end", {31'd0, inst_valid}, 32'd0);

        // Stall held for three cycles over delivery of 0x4
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h2222_0000;
        step();
        imem_rdata = 32'h2222_0004; stall = 1'b1;
        step();
        imem_ack = 1'b0;
        check("stall0_valid", {31'd0, inst_valid}, 32'd1);
        check("stall0_pcout", pc_out, 32'h4);
        check("stall0_req", {31'd0, imem_req}, 32'd0);
        step();
        step();
        check("stall2_valid", {31'd0, inst_valid}, 32'd1);
        check("stall2_pcout", pc_out, 32'h4);
        check("stall2_inst", inst, 32'h2222_0004);
        check("stall2_req", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        step();
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h8);
        check("resume_valid", {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h2222_0008;
        step();
        check("resume_pcout", pc_out, 32'h8);

        // Branch while waiting for ack on 0xC: target 0x10+4-0x10 = 0x4
        imem_ack = 1'b0;
        branch_taken = 1'b1; branch_pc = 32'h10; branch_offset = 32'hFFFF_FFF0;
        step();
        branch_taken = 1'b0;
        check("sq_req", {31'd0, imem_req}, 32'd1);
        check("sq_old_addr", imem_addr, 32'hC);
        check("sq_valid", {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("sq_drop_valid", {31'd0, inst_valid}, 32'd0);
        check("sq_drop_inst", inst, 32'h2222_0008);
        check("br_addr", imem_addr, 32'h4);
        imem_rdata = 32'h3333_0004;
        step();
        check("br_pcout", pc_out, 32'h4);
        check("br_addr_next", imem_addr, 32'h8);

        // Jump beats branch, coincident with ack: data dropped
        imem_rdata = 32'hBAD0_0008;
        jump_en = 1'b1; jump_target = 32'h400; branch_taken = 1'b1;
        step();
        jump_en = 1'b0; branch_taken = 1'b0;
        check("jmp_prio_addr", imem_addr, 32'h400);
        check("jmp_prio_valid", {31'd0, inst_valid}, 32'd0);
        check("jmp_prio_aerr", {31'd0, addr_err}, 32'd0);

        // Misaligned jump target while waiting on ack
        imem_ack = 1'b0;
        jump_en = 1'b1; jump_target = 32'h402;
        step();
        jump_en = 1'b0;
        check("aerr_pulse", {31'd0, addr_err}, 32'd1);
        step();
        check("aerr_clear", {31'd0, addr_err}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0400;
        step();
        check("aerr_addr", imem_addr, 32'h400);
        check("aerr_valid", {31'd0, inst_valid}, 32'd0);

        // PC wrap at the top of the address space
        jump_en = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        jump_en = 1'b0;
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        imem_rdata = 32'h4444_FFFC;
        step();
        check("wrap_pcout", pc_out, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset mid-fetch, then stray ack ignored in IDLE
        rst = 1'b1;
        #2;
        check_reset_outputs("rst_async");
        rst = 1'b0;
        step();
        check("post_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
